mandelbrot_pixel_writer: RTL and testbench

- Downstream consumer of the mandelbrot core. Accepts retired pixel results (x, y, iteration count) through a valid/ready handshake.
- Buffers results in a small FIFO, maps each iteration count to a colour, and writes it to a framebuffer write port that applies backpressure.
- Counts retired pixels and pulses a frame-complete strobe once every pixel of a RESX*RESY frame has been written.

---
 rtl/mandelbrot_pixel_writer.sv | 172 +++++++++++++++++
 tb/tb_mandelbrot_pixel_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_pixel_writer.sv
// Mandelbrot pixel writer: buffers retired pixel results, maps iteration counts to colour, writes a framebuffer.
// Optional in-set pixel counter is enabled by defining MANDEL_WRITER_INSET_COUNT_EN.
module mandelbrot_pixel_writer #(
  parameter int RESX        = 640,
  parameter int RESY        = 480,
  parameter int IMAX        = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int COLOR_W     = 8,
  parameter int COLOR_SCALE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [10:0]        in_x,
  input  logic [10:0]        in_y,
  input  logic [31:0]        in_iter,
  output logic               fb_we,
  input  logic               fb_ready,
  output logic [21:0]        fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               frame_done,
  output logic [21:0]        pixel_count,
  output logic               range_err
`ifdef MANDEL_WRITER_INSET_COUNT_EN
  ,
  output logic [21:0]        inset_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [21:0] FRAME_LAST = 22'(RESX * RESY - 1);
  localparam logic [39:0] COLOR_MAX  = (40'd1 << COLOR_W) - 40'd1;
`ifdef MANDEL_WRITER_INSET_COUNT_EN
  localparam int ENTRY_W = 1 + 22 + COLOR_W;
`else
  localparam int ENTRY_W = 22 + COLOR_W;
`endif

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_full;
  logic               fifo_empty;

  logic               accept;
  logic               in_range;
  logic               push;
  logic               pop;
  logic               fb_write;

  logic               in_set;
  logic [39:0]        product;
  logic [COLOR_W-1:0] push_color;
  logic [21:0]        push_addr;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // Ready depends only on the registered occupancy, so a pop cannot open a slot in the same cycle.
  assign in_ready = !rst && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign in_range = (in_x < 11'(RESX)) && (in_y < 11'(RESY));
  assign push     = accept && in_range;
  assign fb_write = fb_we && fb_ready;
  assign pop      = !fifo_empty && (!fb_we || fb_ready);

  assign in_set    = (in_iter >= 32'(IMAX));
  assign product   = 40'(in_iter) * 40'(COLOR_SCALE);
  assign push_addr = 22'(in_y) * 22'(RESX) + 22'(in_x);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    push_color = '0;
    if (!in_set) begin
      if (product > COLOR_MAX) push_color = '1;
      else                     push_color = product[COLOR_W-1:0];
    end
  end

`ifdef MANDEL_WRITER_INSET_COUNT_EN
  assign push_entry = {in_set, push_addr, push_color};
`else
  assign push_entry = {push_addr, push_color};
`endif

  assign head_entry = fifo_mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the buffer storage is cleared on reset as well, so no stale record survives a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_entry;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Holding register: refills from the FIFO head whenever it is idle or its write completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else if (pop) begin
      fb_we   <= 1'b1;
      fb_addr <= head_entry[COLOR_W +: 22];
      fb_data <= head_entry[COLOR_W-1:0];
    end else if (fb_write) begin
      fb_we   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_count <= '0;
      frame_done  <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (fb_write) begin
        if (pixel_count == FRAME_LAST) begin
          pixel_count <= '0;
          frame_done  <= 1'b1;
        end else begin
          pixel_count <= pixel_count + 22'd1;
        end
      end
      if (accept && !in_range) range_err <= 1'b1;
    end
  end

`ifdef MANDEL_WRITER_INSET_COUNT_EN
  logic        hold_inset;
  logic [21:0] inset_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_inset  <= 1'b0;
      inset_acc   <= '0;
      inset_count <= '0;
    end else begin
      if (pop) hold_inset <= head_entry[ENTRY_W-1];
      if (fb_write) begin
        if (pixel_count == FRAME_LAST) begin
          inset_count <= inset_acc + 22'(hold_inset);
          inset_acc   <= '0;
        end else begin
          inset_acc   <= inset_acc + 22'(hold_inset);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mandelbrot_pixel_writer.sv
// Directed self-checking bench for mandelbrot_pixel_writer (small 4x2 frame, COLOR_SCALE=32).
module tb_mandelbrot_pixel_writer;

  localparam int RESX        = 4;
  localparam int RESY        = 2;
  localparam int IMAX        = 16;
  localparam int FIFO_DEPTH  = 8;
  localparam int COLOR_W     = 8;
  localparam int COLOR_SCALE = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [10:0]        in_x;
  logic [10:0]        in_y;
  logic [31:0]        in_iter;
  logic               fb_we;
  logic               fb_ready;
  logic [21:0]        fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               frame_done;
  logic [21:0]        pixel_count;
  logic               range_err;
`ifdef MANDEL_WRITER_INSET_COUNT_EN
  logic [21:0]        inset_count;
`endif

  always #5 clk = ~clk;

  mandelbrot_pixel_writer #(
    .RESX(RESX), .RESY(RESY), .IMAX(IMAX), .FIFO_DEPTH(FIFO_DEPTH),
    .COLOR_W(COLOR_W), .COLOR_SCALE(COLOR_SCALE)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_iter(in_iter),
    .fb_we(fb_we), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
    .frame_done(frame_done), .pixel_count(pixel_count), .range_err(range_err)
`ifdef MANDEL_WRITER_INSET_COUNT_EN
    , .inset_count(inset_count)
`endif
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int wa[$];
  int wd[$];
  int fd[$];

  // Log of completed writes; frame_done records how many writes preceded it.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd.push_back(wa.size());
      if (fb_we && fb_ready) begin
        wa.push_back(int'(fb_addr));
        wd.push_back(int'(fb_data));
      end
    end
  end

  task automatic check(input string tag, input int observed, input int expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    fd.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 ns after a rising edge; returns 1 ns after the edge that accepted the record.
  task automatic push(input int x, input int y, input int it);
    int n;
    in_x     = 11'(x);
    in_y     = 11'(y);
    in_iter  = 32'(it);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_compared++;
      n_mismatched++;
      $error("FAIL push_timeout: observed in_ready stuck low expected accept of x=%0d y=%0d", x, y);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_write(input string tag, input int idx, input int addr, input int data);
    if (idx < wa.size()) begin
      check({tag, "_addr"}, wa[idx], addr);
      check({tag, "_data"}, wd[idx], data);
    end else begin
      check({tag, "_missing"}, wa.size(), idx + 1);
    end
  endtask

  int t1_addr [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int t1_data [8] = '{0, 32, 64, 96, 32, 64, 96, 128};
  int t3_addr [9] = '{3, 4, 5, 6, 7, 0, 1, 2, 3};
  int t3_data [9] = '{32, 64, 96, 128, 160, 192, 224, 255, 255};
  int t3_x    [9] = '{3, 0, 1, 2, 3, 0, 1, 2, 3};
  int t3_y    [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    in_iter  = '0;
    fb_ready = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_data", int'(fb_data), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_pixel_count", int'(pixel_count), 0);
    check("rst_range_err", int'(range_err), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Full 4x2 frame, iter = x + y
    fb_ready = 1'b1;
    clear_log();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        push(x, y, x + y);
    wait_cycles(6);
    check("t1_nwrites", wa.size(), 8);
    for (int i = 0; i < 8; i++) check_write($sformatf("t1_w%0d", i), i, t1_addr[i], t1_data[i]);
    check("t1_nframe_done", fd.size(), 1);
    if (fd.size() > 0) check("t1_frame_done_at", fd[0], 8);
    check("t1_pixel_count", int'(pixel_count), 0);
    check("t1_fb_we_idle", int'(fb_we), 0);
`ifdef MANDEL_WRITER_INSET_COUNT_EN
    check("t1_inset_count", int'(inset_count), 0);
`endif

    // Colour mapping: in-set points and saturation; two-cycle latency
    clear_log();
    push(0, 0, 16);
    check("t2_lat_early", int'(fb_we), 0);
    wait_cycles(1);
    check("t2_lat_we", int'(fb_we), 1);
    check("t2_lat_addr", int'(fb_addr), 0);
    push(1, 0, 20);
    push(2, 0, 15);
    wait_cycles(4);
    check("t2_nwrites", wa.size(), 3);
    check_write("t2_w0", 0, 0, 0);
    check_write("t2_w1", 1, 1, 0);
    check_write("t2_w2", 2, 2, 255);
    check("t2_pixel_count", int'(pixel_count), 3);

    // Backpressure: holding register + full FIFO, then drain
    fb_ready = 1'b0;
    clear_log();
    for (int i = 0; i < 9; i++) push(t3_x[i], t3_y[i], i + 1);
    check("t3_in_ready_full", int'(in_ready), 0);
    check("t3_hold_we", int'(fb_we), 1);
    check("t3_hold_addr", int'(fb_addr), 3);
    check("t3_hold_data", int'(fb_data), 32);
    wait_cycles(3);
    check("t3_stable_addr", int'(fb_addr), 3);
    check("t3_stable_data", int'(fb_data), 32);
    check("t3_stable_we", int'(fb_we), 1);
    check("t3_still_full", int'(in_ready), 0);
    check("t3_no_writes", wa.size(), 0);
    fb_ready = 1'b1;
    wait_cycles(12);
    check("t3_nwrites", wa.size(), 9);
    for (int i = 0; i < 9; i++) check_write($sformatf("t3_w%0d", i), i, t3_addr[i], t3_data[i]);
    check("t3_nframe_done", fd.size(), 1);
    if (fd.size() > 0) check("t3_frame_done_at", fd[0], 5);
    check("t3_pixel_count", int'(pixel_count), 4);
    check("t3_in_ready", int'(in_ready), 1);
`ifdef MANDEL_WRITER_INSET_COUNT_EN
    check("t3_inset_count", int'(inset_count), 2);
`endif

    // Out-of-range records are dropped and flagged
    clear_log();
    push(4, 0, 1);
    wait_cycles(1);
    check("t4_range_err", int'(range_err), 1);
    push(0, 2, 1);
    wait_cycles(4);
    check("t4_no_writes", wa.size(), 0);
    check("t4_no_we", int'(fb_we), 0);
    check("t4_pixel_count", int'(pixel_count), 4);
    push(0, 1, 2);
    wait_cycles(4);
    check("t4_nwrites", wa.size(), 1);
    check_write("t4_w0", 0, 4, 64);
    check("t4_range_err_sticky", int'(range_err), 1);
    check("t4_pixel_count_after", int'(pixel_count), 5);

    // Reset mid-operation with records buffered and a write pending
    fb_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(i % 4, i / 4, 1);
    wait_cycles(1);
    check("t5_we_before", int'(fb_we), 1);
    clear_log();
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    check("t5_fb_we", int'(fb_we), 0);
    check("t5_pixel_count", int'(pixel_count), 0);
    check("t5_range_err", int'(range_err), 0);
    check("t5_fb_addr", int'(fb_addr), 0);
    check("t5_fb_data", int'(fb_data), 0);
    fb_ready = 1'b1;
    wait_cycles(20);
    check("t5_no_stale", wa.size(), 0);
    check("t5_in_ready", int'(in_ready), 1);
`ifdef MANDEL_WRITER_INSET_COUNT_EN
    check("t5_inset_count", int'(inset_count), 0);
`endif
    push(1, 1, 3);
    wait_cycles(4);
    check("t5_nwrites", wa.size(), 1);
    check_write("t5_w0", 0, 5, 96);
    check("t5_pixel_count_after", int'(pixel_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected $finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
